// File: rtl/bist_ctrl_if.sv
// Signal bundle between the BIST sequencer, its functional driver and the sync-detector CUT.
interface bist_ctrl_if;
  logic       bist_start;
  logic       in_k;
  logic       in_j;
  logic       in_en;
  logic       cut_k;
  logic       cut_j;
  logic       cut_en;
  logic       cut_init;
  logic       cut_synced_d;
  logic       cut_sync_err_d;
  logic       bist_busy;
  logic       bist_end;
  logic       pass_fail;
  logic [2:0] state_dbg;

  // Start/end handshake: a rising edge of bist_start in IDLE or DONE launches a run;
  // bist_busy stays high until bist_end rises, and pass_fail is valid only while bist_end=1.
  modport slave (
    input  bist_start, in_k, in_j, in_en, cut_synced_d, cut_sync_err_d,
    output cut_k, cut_j, cut_en, cut_init, bist_busy, bist_end, pass_fail, state_dbg
  );

  modport master (
    output bist_start, in_k, in_j, in_en, cut_synced_d, cut_sync_err_d,
    input  cut_k, cut_j, cut_en, cut_init, bist_busy, bist_end, pass_fail, state_dbg
  );
endinterface

// File: rtl/bist_ctrl.sv
// BIST sequencer: takes over the sync-detector CUT inputs, drives LFSR patterns,
// compacts the responses in a MISR and compares the result against a golden signature.
module bist_ctrl #(
  parameter int         N_PATTERNS = 1000,
  parameter int         RESP_LAT   = 1,
  parameter logic [7:0] LFSR_SEED  = 8'h01,
  parameter logic [7:0] MISR_SEED  = 8'h00,
  parameter logic [7:0] GOLDEN_SIG = 8'h00
) (
  input logic        clk,
  input logic        rst_n,
  bist_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(N_PATTERNS + RESP_LAT + 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             start_q;
  logic             armed;
  logic             go;
  logic [7:0]       lfsr;
  logic [7:0]       misr;
  logic [7:0]       lfsr_next;
  logic [7:0]       misr_next;
  logic [CNT_W-1:0] cnt;
  logic             pass_q;

  // armed stays low until bist_start has been seen low, so a start held across reset is not an edge.
  assign go        = bus.bist_start & ~start_q & armed;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_next = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]}
                     ^ {6'b0, bus.cut_sync_err_d, bus.cut_synced_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_d;
      start_q <= bus.bist_start;
      if (!bus.bist_start) armed <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state;
    bus.cut_k     = bus.in_k;
    bus.cut_j     = bus.in_j;
    bus.cut_en    = bus.in_en;
    bus.cut_init  = 1'b0;
    bus.bist_busy = 1'b0;
    bus.bist_end  = 1'b0;
    bus.pass_fail = pass_q;
    bus.state_dbg = state;
    case (state)
      S_IDLE: begin
        if (go) state_d = S_INIT;
      end
      S_INIT: begin
        bus.cut_init  = 1'b1;
        bus.bist_busy = 1'b1;
        {bus.cut_k, bus.cut_j, bus.cut_en} = 3'b000;
        state_d = S_RUN;
      end
      S_RUN: begin
        bus.bist_busy = 1'b1;
        {bus.cut_k, bus.cut_j, bus.cut_en} = lfsr[2:0];
        if (cnt == RUN_LAST) state_d = (RESP_LAT == 0) ? S_COMPARE : S_FLUSH;
      end
      S_FLUSH: begin
        bus.bist_busy = 1'b1;
        {bus.cut_k, bus.cut_j, bus.cut_en} = 3'b000;
        if (cnt == FLUSH_LAST) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        bus.bist_busy = 1'b1;
        {bus.cut_k, bus.cut_j, bus.cut_en} = 3'b000;
        state_d = S_DONE;
      end
      S_DONE: begin
        bus.bist_end = 1'b1;
        if (go) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      misr   <= MISR_SEED;
      cnt    <= '0;
      pass_q <= 1'b0;
    end else begin
      if (state_d != state) begin
        cnt <= '0;
      end else if (state == S_RUN || state == S_FLUSH) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        S_INIT: begin
          lfsr <= LFSR_SEED;
          misr <= MISR_SEED;
        end
        S_RUN: begin
          lfsr <= lfsr_next;
          misr <= misr_next;
        end
        S_FLUSH: misr <= misr_next;
        default: ;
      endcase

      // The edge that enters INIT drops the previous verdict together with bist_end.
      if (state_d == S_INIT) begin
        pass_q <= 1'b0;
      end else if (state == S_COMPARE) begin
        pass_q <= (misr == GOLDEN_SIG);
      end
    end
  end

endmodule
